// File: rtl/chain_driver.sv
// ---------------------------------------------------------------------------
// chain_driver
//
// Serialises frames from a registered-read framebuffer into c_chains parallel
// daisy-chains of constant-current LED drivers. All chains share one serial
// clock (o_clk) and one latch (o_lat). Each chain has its own data lane
// (o_dai[k]). An internal free-running timer paces frames. A tick that
// arrives while a frame is still in flight is dropped and reported on
// o_overrun. The frame in progress is left untouched.
//
// Ports
//   i_clk          : the only clock, rising edge
//   i_rst          : synchronous, active-high reset
//   i_en           : allows a frame to start; looked at only on a tick
//   i_data         : one channel word per chain, lane k at [k*c_bpc +: c_bpc]
//                    (comes from the framebuffer, one cycle after o_addr)
//   o_addr         : framebuffer channel address shared by all chains
//   o_clk          : serial shift clock to the drivers
//   o_dai          : serial data, one bit per chain
//   o_lat          : latch pulse; doubles as the data request to the animator
//   o_busy         : high while a frame is in progress
//   o_frame_done   : one-cycle pulse at the end of a frame
//   o_overrun      : one-cycle pulse after a tick that hit a busy frame
//
// Every output comes straight from a flop. No input reaches an output
// through combinational logic.
// ---------------------------------------------------------------------------
module chain_driver #(
  parameter int c_chains       = 2,
  parameter int c_ledboards    = 1,
  parameter int c_bpc          = 12,
  parameter int c_frame_period = 16666,
  parameter int c_lat_cycles   = 2,
  localparam int c_n           = c_ledboards * 32,
  localparam int c_addr_w      = $clog2(c_n)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic [c_chains*c_bpc-1:0]   i_data,
  output logic [c_addr_w-1:0]         o_addr,
  output logic                        o_clk,
  output logic [c_chains-1:0]         o_dai,
  output logic                        o_lat,
  output logic                        o_busy,
  output logic                        o_frame_done,
  output logic                        o_overrun
);

  // The +1 keeps the widths non-zero for degenerate parameter values
  // (period 1, a single latch cycle).
  localparam int c_timer_w = $clog2(c_frame_period + 1);
  localparam int c_bit_w   = $clog2(c_bpc);
  localparam int c_lat_w   = $clog2(c_lat_cycles + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LD    = 3'd2,
    ST_SHL   = 3'd3,
    ST_SHH   = 3'd4,
    ST_LATCH = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t                state_reg;
  logic [c_timer_w-1:0]  timer_reg;
  logic [c_bit_w-1:0]    bit_cnt_reg;
  logic [c_lat_w-1:0]    lat_cnt_reg;
  logic [c_addr_w-1:0]   addr_reg;
  logic                  sclk_reg;
  logic                  lat_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  overrun_reg;

  logic                  tick;
  logic                  lane_load;
  logic                  lane_shift;
  logic                  more_bits;

  // The tick is the edge at which the timer wraps from period-1 back to 0.
  assign tick       = (timer_reg == c_timer_w'(c_frame_period - 1));

  // Strobes shared by all lanes. The lanes follow the controller in lock step.
  assign lane_load  = (state_reg == ST_LD);
  assign lane_shift = (state_reg == ST_SHH);
  assign more_bits  = (bit_cnt_reg != '0);

  // -------------------------------------------------------------------------
  // Frame timer and sequencing controller
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
      lat_cnt_reg <= '0;
      addr_reg    <= '0;
      sclk_reg    <= 1'b0;
      lat_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      // The timer free-runs whatever the enable or the frame state.
      timer_reg   <= tick ? '0 : timer_reg + c_timer_w'(1);

      // A tick that lands in any state other than IDLE is lost. It only
      // raises the flag, and the frame in flight carries on unchanged.
      overrun_reg <= tick && (state_reg != ST_IDLE);
      done_reg    <= 1'b0;

      unique case (state_reg)
        ST_IDLE: begin
          if (tick && i_en) begin
            addr_reg  <= c_addr_w'(c_n - 1);
            busy_reg  <= 1'b1;
            state_reg <= ST_RD;
          end
        end

        // The framebuffer read is registered, so wait one cycle after
        // o_addr moves before the word appears on i_data.
        ST_RD: begin
          state_reg <= ST_LD;
        end

        ST_LD: begin
          bit_cnt_reg <= c_bit_w'(c_bpc - 1);
          sclk_reg    <= 1'b0;
          state_reg   <= ST_SHL;
        end

        ST_SHL: begin
          sclk_reg  <= 1'b1;
          state_reg <= ST_SHH;
        end

        ST_SHH: begin
          sclk_reg <= 1'b0;
          if (more_bits) begin
            bit_cnt_reg <= bit_cnt_reg - c_bit_w'(1);
            state_reg   <= ST_SHL;
          end else if (addr_reg != '0) begin
            addr_reg  <= addr_reg - c_addr_w'(1);
            state_reg <= ST_RD;
          end else begin
            lat_reg     <= 1'b1;
            lat_cnt_reg <= c_lat_w'(c_lat_cycles - 1);
            state_reg   <= ST_LATCH;
          end
        end

        // The latch stays high for exactly c_lat_cycles cycles. It was
        // raised on the way in and counts down from c_lat_cycles-1.
        ST_LATCH: begin
          if (lat_cnt_reg == '0) begin
            lat_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - c_lat_w'(1);
          end
        end

        ST_DONE: begin
          addr_reg  <= '0;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Per-chain shift lanes
  //
  // Each lane holds its word in a shift register and keeps its own output
  // flop. The data bit is registered on the same edge that drops o_clk, so
  // it is stable through the whole low phase and the following rising edge.
  // After the last bit of a word the lane returns to 0, so the line sits
  // quiet during the read and latch gaps.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < c_chains; gi++) begin : g_lane
    logic [c_bpc-1:0] shift_reg;
    logic             dai_reg;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        shift_reg <= '0;
        dai_reg   <= 1'b0;
      end else if (lane_load) begin
        shift_reg <= i_data[gi*c_bpc +: c_bpc];
        dai_reg   <= i_data[gi*c_bpc + c_bpc - 1];
      end else if (lane_shift) begin
        shift_reg <= shift_reg << 1;
        // After the shift, the next MSB is the bit just below the current one.
        dai_reg   <= more_bits ? shift_reg[c_bpc-2] : 1'b0;
      end
    end

    assign o_dai[gi] = dai_reg;
  end

  assign o_addr       = addr_reg;
  assign o_clk        = sclk_reg;
  assign o_lat        = lat_reg;
  assign o_busy       = busy_reg;
  assign o_frame_done = done_reg;
  assign o_overrun    = overrun_reg;

endmodule

// File: tb/tb_chain_driver.sv
// ---------------------------------------------------------------------------
// tb_chain_driver
//
// Bench for chain_driver: 2 chains, 1 board, 12 bits, a 2-cycle latch and a
// 500-cycle frame period. With that period every frame also sees an overrun
// tick at frame cycle 500. A frame-level model predicts every output from
// the frame-relative cycle number, and a negedge process compares them.
// Directed steps also check literal hand-computed values.
// ---------------------------------------------------------------------------
module tb_chain_driver;

  localparam int CH = 2;
  localparam int B  = 12;
  localparam int P  = 500;
  localparam int L  = 2;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int WL = 2 + 2 * B;     // cycles per word
  localparam int W  = N * WL;        // 832

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_en  = 1'b1;
  logic [CH*B-1:0]   i_data = '0;
  logic [AW-1:0]     o_addr;
  logic              o_clk;
  logic [CH-1:0]     o_dai;
  logic              o_lat;
  logic              o_busy;
  logic              o_frame_done;
  logic              o_overrun;

  chain_driver #(
    .c_chains(CH), .c_ledboards(1), .c_bpc(B),
    .c_frame_period(P), .c_lat_cycles(L)
  ) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_data(i_data),
    .o_addr(o_addr), .o_clk(o_clk), .o_dai(o_dai), .o_lat(o_lat),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Framebuffer with a registered read port
  logic [B-1:0] fb [CH][N];

  always @(posedge i_clk) begin
    for (int k = 0; k < CH; k++) i_data[k*B +: B] <= fb[k][o_addr];
  end

  int nchk  = 0;
  int npass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // -------------------------------------------------------------------------
  // Frame-level model: the edge count since reset release gives the ticks,
  // and the frame-relative cycle m_fc gives every output.
  // -------------------------------------------------------------------------
  int m_edges = 0;
  bit m_act   = 1'b0;
  int m_fc    = 0;
  bit m_ovr   = 1'b0;

  always @(posedge i_clk) begin : model
    bit tick_now;
    bit was_act;
    if (i_rst) begin
      m_edges = 0;
      m_act   = 1'b0;
      m_fc    = 0;
      m_ovr   = 1'b0;
    end else begin
      m_edges++;
      tick_now = (m_edges % P) == 0;
      was_act  = m_act;
      m_ovr    = tick_now && was_act;
      if (m_act) begin
        m_fc++;
        if (m_fc > W + L) m_act = 1'b0;
      end
      if (tick_now && !was_act && i_en) begin
        m_act = 1'b1;
        m_fc  = 0;
      end
    end
  end

  always @(negedge i_clk) begin : compare
    int j, r, q, ea;
    logic [CH-1:0] e_dai;
    bit e_clk, e_lat, e_busy, e_done, dai_valid;
    if (chk_en) begin
      ea = 0; e_dai = '0; e_clk = 0; e_lat = 0; e_busy = 0; e_done = 0; dai_valid = 1;
      if (m_act) begin
        if (m_fc < W) begin
          j = m_fc / WL;
          r = m_fc % WL;
          ea = N - 1 - j;
          e_busy = 1;
          if (r < 2) begin
            dai_valid = 0;
          end else begin
            q = (r - 2) / 2;
            e_clk = ((r - 2) % 2) == 1;
            for (int k = 0; k < CH; k++) e_dai[k] = fb[k][ea][B-1-q];
          end
        end else if (m_fc < W + L) begin
          e_lat = 1; e_busy = 1;
        end else begin
          e_done = 1;
        end
      end
      chk("addr", o_addr, ea);
      chk("sclk", o_clk, e_clk);
      chk("lat", o_lat, e_lat);
      chk("busy", o_busy, e_busy);
      chk("frame_done", o_frame_done, e_done);
      chk("overrun", o_overrun, m_ovr);
      if (dai_valid) chk("dai", o_dai, e_dai);
    end
  end

  // -------------------------------------------------------------------------
  // Directed helpers
  // -------------------------------------------------------------------------
  int rises, lat_first, done_cyc, ovr_cyc, ncap;
  bit cap0 [N*B];
  bit cap1 [N*B];

  task automatic wait_busy(input int budget, output int waited);
    waited = 0;
    while (o_busy !== 1'b1 && waited < budget) begin
      @(negedge i_clk);
      waited++;
    end
    if (o_busy !== 1'b1) chk("busy_timeout", o_busy, 1);
  endtask

  // Called on the negedge of frame cycle 0. Returns on the done cycle.
  task automatic measure_frame();
    bit prev_clk;
    bit got_done;
    rises = 0; lat_first = -1; done_cyc = -1; ovr_cyc = -1; ncap = 0;
    prev_clk = 0; got_done = 0;
    for (int c = 0; c < 1000 && !got_done; c++) begin
      if (o_clk && !prev_clk) begin
        rises++;
        if (ncap < N * B) begin
          cap0[ncap] = o_dai[0];
          cap1[ncap] = o_dai[1];
          ncap++;
        end
      end
      prev_clk = o_clk;
      if (o_lat && lat_first < 0) lat_first = c;
      if (o_overrun && ovr_cyc < 0) ovr_cyc = c;
      if (o_frame_done) begin
        done_cyc = c;
        got_done = 1;
      end else begin
        @(negedge i_clk);
      end
    end
    if (!got_done) chk("frame_done_timeout", 0, 1);
  endtask

  function automatic logic [B-1:0] cap_word(input int lane, input int w);
    logic [B-1:0] v;
    for (int b = 0; b < B; b++) v[B-1-b] = (lane == 0) ? cap0[w*B + b] : cap1[w*B + b];
    return v;
  endfunction

  initial begin
    int waited, busy_cnt, ovr_cnt, pc0, pc1;
    bit seen;
    for (int a = 0; a < N; a++) begin
      fb[0][a] = B'(a);
      fb[1][a] = ~B'(a);
    end

    // Reset for 5 cycles with enable held high
    i_rst = 1; i_en = 1;
    @(negedge i_clk);
    chk_en = 1;
    repeat (4) @(negedge i_clk);
    chk("rst_addr", o_addr, 0);
    chk("rst_dai", o_dai, 0);
    chk("rst_busy", o_busy, 0);
    $display("txn reset: addr=%0d dai=%0b busy=%0b", o_addr, o_dai, o_busy);
    i_rst = 0;

    // Frame 1: chain 0 = addr, chain 1 = ~addr
    wait_busy(600, waited);
    chk("first_tick_cycle", waited, 500);
    chk("first_addr", o_addr, 31);
    measure_frame();
    chk("f1_rises", rises, 384);
    chk("f1_lat_first", lat_first, 832);
    chk("f1_done_cycle", done_cyc, 834);
    chk("f1_overrun_cycle", ovr_cyc, 500);
    chk("f1_word0_lane0", cap_word(0, 0), 12'h01F);
    chk("f1_word0_lane1", cap_word(1, 0), 12'hFE0);
    chk("f1_word31_lane1", cap_word(1, 31), 12'hFFF);
    $display("txn frame1: rises=%0d lat=%0d done=%0d ovr=%0d", rises, lat_first, done_cyc, ovr_cyc);

    // Frame 2: bit-order pattern, loaded while idle
    @(negedge i_clk);
    for (int k = 0; k < CH; k++)
      for (int a = 0; a < N; a++) fb[k][a] = '0;
    for (int k = 0; k < CH; k++) begin
      fb[k][31] = 12'h800;
      fb[k][0]  = 12'h001;
    end
    wait_busy(300, waited);
    measure_frame();
    pc0 = 0; pc1 = 0;
    for (int i = 0; i < N * B; i++) begin
      pc0 += int'(cap0[i]);
      pc1 += int'(cap1[i]);
    end
    chk("order_rises", rises, 384);
    chk("order_first_bit", cap0[0], 1);
    chk("order_last_bit", cap0[N*B-1], 1);
    chk("order_ones_lane0", pc0, 2);
    chk("order_ones_lane1", pc1, 2);
    $display("txn bitorder: first=%0b last=%0b ones=%0d/%0d", cap0[0], cap0[N*B-1], pc0, pc1);

    // Enable low across 3 ticks
    i_en = 0;
    busy_cnt = 0; ovr_cnt = 0;
    repeat (1600) begin
      @(negedge i_clk);
      busy_cnt += int'(o_busy);
      ovr_cnt  += int'(o_overrun);
    end
    chk("gated_busy", busy_cnt, 0);
    chk("gated_overrun", ovr_cnt, 0);
    $display("txn gated: busy_cycles=%0d overruns=%0d", busy_cnt, ovr_cnt);

    // Enable dropped at cycle 100 of a frame
    i_en = 1;
    wait_busy(200, waited);
    repeat (100) @(negedge i_clk);
    i_en = 0;
    seen = 0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge i_clk);
      if (o_frame_done) seen = 1;
    end
    chk("middrop_frame_done", seen, 1);
    busy_cnt = 0;
    repeat (700) begin
      @(negedge i_clk);
      busy_cnt += int'(o_busy);
    end
    chk("middrop_no_restart", busy_cnt, 0);
    $display("txn middrop: done=%0b busy_after=%0d", seen, busy_cnt);

    // Reset at cycle 50 of a frame
    i_en = 1;
    wait_busy(600, waited);
    repeat (50) @(negedge i_clk);
    i_rst = 1;
    @(negedge i_clk);
    chk("midrst_sclk", o_clk, 0);
    chk("midrst_dai", o_dai, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_addr", o_addr, 0);
    i_rst = 0;
    wait_busy(600, waited);
    chk("midrst_restart_cycle", waited, 500);
    chk("midrst_restart_addr", o_addr, 31);
    $display("txn midreset: restart_after=%0d addr=%0d", waited, o_addr);
    repeat (900) @(negedge i_clk);

    chk_en = 0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
